multicycle_controller: RTL

- Multi-cycle successor to the single-cycle RISC-V main decoder: an FSM that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared instruction/data memory with a ready handshake.
- Drives the same datapath control set (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch, JalrSel, RWSel), plus PC/IR write enables.
- Adds HALT and illegal-opcode trap states, a memory-wait timeout and a retired-instruction counter.

---
 rtl/multicycle_controller.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory
// with a ready handshake, plus halt/illegal/bus-timeout traps and a retired-instruction counter.
module multicycle_controller #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic             JalrSel,
    output logic [1:0]       ALUOp,
    output logic [1:0]       RWSel,
    output logic [2:0]       state_o,
    output logic             halted,
    output logic             illegal,
    output logic             bus_error,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalted = 3'd5,
        StTrap   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        ClsNone,
        ClsR,
        ClsImm,
        ClsLw,
        ClsSw,
        ClsBr,
        ClsLui,
        ClsJal,
        ClsJalr,
        ClsHalt
    } cls_e;

    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpImm  = 7'b0010011;
    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpBr   = 7'b1100011;
    localparam logic [6:0] OpLui  = 7'b0110111;
    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [6:0] OpJalr = 7'b1100111;
    localparam logic [6:0] OpHalt = 7'b1111111;

    // Counter only has to reach TIMEOUT-1: the trap fires on that wait cycle.
    localparam int unsigned    TmoW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    cls_e              cls_q, cls_d, op_cls;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;
    logic              tmo_hit;
    logic              in_wait;
    logic              asrc_cls;
    logic [1:0]        aop_cls;

    always_comb begin
        op_cls = ClsNone;
        case (Opcode)
            OpR:     op_cls = ClsR;
            OpImm:   op_cls = ClsImm;
            OpLw:    op_cls = ClsLw;
            OpSw:    op_cls = ClsSw;
            OpBr:    op_cls = ClsBr;
            OpLui:   op_cls = ClsLui;
            OpJal:   op_cls = ClsJal;
            OpJalr:  op_cls = ClsJalr;
            OpHalt:  op_cls = ClsHalt;
            default: op_cls = ClsNone;
        endcase
    end

    assign in_wait = (state_q == StFetch) || (state_q == StMem);
    // A ready in the timeout cycle completes the request instead of trapping.
    assign tmo_hit = (TIMEOUT != 0) && in_wait && !mem_ready && (tmo_q == TmoLast);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (tmo_hit) begin
                    state_d = StTrap;
                end
            end
            StDecode: begin
                if (op_cls == ClsHalt) begin
                    state_d = StHalted;
                end else if (op_cls == ClsNone) begin
                    state_d = StTrap;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cls_q == ClsBr) begin
                    state_d = StFetch;
                end else if ((cls_q == ClsLw) || (cls_q == ClsSw)) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (mem_ready) begin
                    state_d = (cls_q == ClsSw) ? StFetch : StWb;
                end else if (tmo_hit) begin
                    state_d = StTrap;
                end
            end
            StWb:     state_d = StFetch;
            StHalted: state_d = StHalted;
            StTrap:   state_d = StTrap;
            default:  state_d = StTrap;
        endcase
    end

    always_comb begin
        cls_d     = (state_q == StDecode) ? op_cls : cls_q;
        illegal_d = illegal_q | ((state_q == StDecode) && (op_cls == ClsNone));
        bus_err_d = bus_err_q | tmo_hit;
        instret_d = instret_q + CNT_W'(PCWrite);
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (in_wait && !mem_ready) begin
            tmo_d = tmo_q + TmoW'(1);
        end else begin
            tmo_d = tmo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cls_q     <= ClsNone;
            tmo_q     <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            cls_q     <= cls_d;
            tmo_q     <= tmo_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // JALR uses the add encoding: its target is rs1 + imm.
    always_comb begin
        asrc_cls = (cls_q == ClsLw) || (cls_q == ClsSw) || (cls_q == ClsImm) ||
                   (cls_q == ClsJalr);
        unique case (cls_q)
            ClsBr:         aop_cls = 2'b01;
            ClsR, ClsImm:  aop_cls = 2'b10;
            ClsJal, ClsLui: aop_cls = 2'b11;
            default:       aop_cls = 2'b00;
        endcase
    end

    // Output logic; reset forces every control low so an abandoned instruction writes nothing.
    always_comb begin
        mem_req  = 1'b0;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        JalrSel  = 1'b0;
        ALUOp    = 2'b00;
        RWSel    = 2'b00;
        if (!reset) begin
            unique case (state_q)
                StFetch: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    IRWrite = mem_ready;
                end
                StExec: begin
                    ALUSrc  = asrc_cls;
                    ALUOp   = aop_cls;
                    JalrSel = (cls_q == ClsJalr);
                    Branch  = (cls_q == ClsBr);
                    PCWrite = (cls_q == ClsBr);
                end
                StMem: begin
                    mem_req  = 1'b1;
                    ALUSrc   = asrc_cls;
                    ALUOp    = aop_cls;
                    MemRead  = (cls_q == ClsLw);
                    MemWrite = (cls_q == ClsSw);
                    PCWrite  = (cls_q == ClsSw) && mem_ready;
                end
                StWb: begin
                    ALUSrc   = asrc_cls;
                    ALUOp    = aop_cls;
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    MemtoReg = (cls_q == ClsLw);
                    Branch   = (cls_q == ClsJal);
                    JalrSel  = (cls_q == ClsJalr);
                    if ((cls_q == ClsJal) || (cls_q == ClsJalr)) begin
                        RWSel = 2'b01;
                    end else if (cls_q == ClsLui) begin
                        RWSel = 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_o   = state_q;
    assign halted    = (state_q == StHalted);
    assign illegal   = illegal_q;
    assign bus_error = bus_err_q;
    assign instret   = instret_q;

endmodule
